delaychain_tester: RTL and testbench
====================================

# delaychain_tester

Self-checking stimulus/response engine for the flip-flop delay-chain test structures. It drives every chain input with a marker pulse, measures the chain latency, and then streams PRBS7 through the chains. It checks each chain output with a self-synchronising PRBS7 checker and counts bit errors per lane. It is the driving and receiving end of the chain lanes, replacing direct pin stimulus and pin observation.

## Interface
- `LANES`, 8: number of chain lanes.
- `MAX_LAT`, 255: latency measurement limit and flush length, in cycles.
- `LATW`, 8: width of the latency counter; must satisfy 2^LATW > MAX_LAT.
- `ERRW`, 16: width of each per-lane error counter.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a test. Ignored unless the block is in IDLE.
- `stop` in 1: ends the RUN phase. Ignored in every other state.
- `err_sel` in $clog2(LANES): lane whose error count appears on `err_count`.
- `chain_din` out LANES: drives the chain inputs.
- `chain_dout` in LANES: returns from the chain outputs.
- `busy` out 1: high in every state except IDLE.
- `lat_valid` out 1: a latency was captured in the current test.
- `timeout` out 1: no marker arrived on lane 0 within MAX_LAT cycles.
- `latency` out LATW: measured lane 0 latency, in cycles.
- `lat_skew` out LANES: lane's marker did not arrive on the same cycle as lane 0.
- `err_any` out LANES: sticky flag, lane saw at least one error.
- `err_count` out ERRW: error count of lane `err_sel`. Combinational mux of registered counters.

## Operation
- The FSM states are IDLE, FLUSH, PULSE, MEASURE, RUN.
- **IDLE:** `chain_din` = 0. On `start`:
  - clear `latency`, `lat_valid`, `timeout`, `lat_skew`, `err_any` and all error counters;
  - go to FLUSH.
- **FLUSH:** `chain_din` = 0 for MAX_LAT cycles, then go to PULSE.
- **PULSE:** exactly one cycle with `chain_din` = all ones, then go to MEASURE. The latency counter is loaded with 1.
- **MEASURE:** `chain_din` = 0. Each cycle:
  - If `chain_dout[0]` = 1: `latency` ← counter, `lat_valid` ← 1.
  - In the same cycle, `lat_skew[i]` ← 1 for every lane i with `chain_dout[i]` = 0. Go to RUN.
  - Else, if counter = MAX_LAT: `timeout` ← 1 and go to IDLE.
  - Else, counter increments.
  - A lane whose `chain_dout` is 1 in any earlier MEASURE cycle is also flagged in `lat_skew`.
- **RUN:**
  - Generator: PRBS7, polynomial x^7+x^6+1, seed 7'h7F on entry to RUN. The same bit drives all lanes.
  - Checker: each lane keeps a 7-bit history of received bits. expected = hist[6] ^ hist[5]; an error is `chain_dout[i]` ≠ expected.
  - Warm-up: comparison is disabled for the first `latency`+7 RUN cycles.
  - Each error increments that lane's counter, saturating at 2^ERRW−1, and sets `err_any[i]`.
  - A single flipped bit in a lane produces exactly 3 errors.
  - `stop` → IDLE. Results hold until the next `start`.
- **Simultaneous events:** `stop` and an error in the same cycle count the error. `start` while `busy` is ignored.
- **Reset:** `rst` at any time forces IDLE immediately. All outputs clear, the LFSR returns to seed, and `chain_din` = 0.

## Timing
- All outputs except `err_count` are registered.
- Reset values: `chain_din`=0, `busy`=0, `lat_valid`=0, `timeout`=0, `latency`=0, `lat_skew`=0, `err_any`=0, all counters 0.
- A chain of N flops, sampled as registered, returns `latency` = N.
- `start` → `busy` high on the next cycle.
- FLUSH lasts MAX_LAT cycles and PULSE lasts 1 cycle.
- The first RUN cycle is the one after capture. Its `chain_din` is bit 0 of the seed state.
- Error counters update on the cycle after the mismatched sample.
- `err_sel` change is reflected on `err_count` in the same cycle.

## Structure
- **Package `delaychain_pkg`:**
  - FSM state enum;
  - PRBS7 seed and tap constants;
  - default MAX_LAT.
- **Sub-module `prbs7_check`:** one lane: history register, warm-up gating, saturating counter and sticky flag. Instantiated LANES times in a generate loop.
- The generator LFSR, the FSM and the latency counter live in the top module.

## Test plan
- 80-flop chain model on all lanes, start, run 2000 cycles → `latency`=80, `lat_valid`=1, `lat_skew`=0, all `err_count`=0.
- Invert one bit of lane 3 at RUN cycle 500 → lane 3 `err_count`=3 and `err_any`=8'h08; all other lanes 0.
- Lane 5 modelled with 81 flops → `latency`=80, `lat_skew`=8'h20. Lane 5 ends with `err_count` 0 after warm-up, since the self-synchronising checker is latency-independent.
- `chain_dout` stuck at 0 → `timeout`=1 after MAX_LAT MEASURE cycles, FSM back in IDLE, `lat_valid`=0.
- Force lane 0 stuck at 1 during RUN for 65600 errors → lane 0 `err_count` saturates at 16'hFFFF.
- Assert `rst` mid-RUN, then `start` during FLUSH of a new test → all outputs zero on reset, the second `start` is ignored, and the new test completes normally.

Source files
------------

// File: rtl/delaychain_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : delaychain_pkg                                               |
// | Description : Shared types and constants for the delay-chain tester:       |
// |               FSM state encoding, PRBS7 seed/taps, default MAX_LAT.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package delaychain_pkg;

   // Tester FSM states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FLUSH   = 3'd1,
      ST_PULSE   = 3'd2,
      ST_MEASURE = 3'd3,
      ST_RUN     = 3'd4
   } state_t;

   // Default latency limit / flush length in cycles
   localparam int c_max_lat_dflt = 255;

   // PRBS7 x^7 + x^6 + 1. The generator state holds the next seven output
   // bits with bit 0 leaving first, so b[n+7] = b[n] ^ b[n+1].
   localparam logic [6:0] c_prbs7_seed     = 7'h7F;
   localparam logic [6:0] c_prbs7_gen_taps = 7'h03;
   // Checker history has the oldest bit at [6]: expected = hist[6] ^ hist[5].
   localparam logic [6:0] c_prbs7_chk_taps = 7'h60;

   function automatic logic [6:0] prbs7_next(input logic [6:0] state);
      return {^(state & c_prbs7_gen_taps), state[6:1]};
   endfunction

   function automatic logic prbs7_expect(input logic [6:0] hist);
      return ^(hist & c_prbs7_chk_taps);
   endfunction

endpackage
`default_nettype wire

// File: rtl/delaychain_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : delaychain_if                                                |
// | Description : Control, status and chain-lane signals of the delay-chain    |
// |               tester. slave = tester side, master = controller/chain side. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface delaychain_if #(
   parameter int LANES = 8,
   parameter int LATW  = 8,
   parameter int ERRW  = 16
);
   logic                     start;
   logic                     stop;
   logic [$clog2(LANES)-1:0] err_sel;
   logic [LANES-1:0]         chain_din;
   logic [LANES-1:0]         chain_dout;
   logic                     busy;
   logic                     lat_valid;
   logic                     timeout;
   logic [LATW-1:0]          latency;
   logic [LANES-1:0]         lat_skew;
   logic [LANES-1:0]         err_any;
   logic [ERRW-1:0]          err_count;

   modport slave (
      input  start, stop, err_sel, chain_dout,
      output chain_din, busy, lat_valid, timeout, latency, lat_skew,
             err_any, err_count
   );

   modport master (
      output start, stop, err_sel, chain_dout,
      input  chain_din, busy, lat_valid, timeout, latency, lat_skew,
             err_any, err_count
   );
endinterface
`default_nettype wire

// File: rtl/delaychain_tester_prbs7_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prbs7_check                                                  |
// | Description : One-lane self-synchronising PRBS7 checker with warm-up       |
// |               gating, saturating error counter and sticky error flag.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prbs7_check
   import delaychain_pkg::*;
#(
   parameter int LATW = 8,
   parameter int ERRW = 16
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            i_clr,
   input  wire logic            i_run,
   input  wire logic [LATW-1:0] i_latency,
   input  wire logic            i_din,
   output logic [ERRW-1:0]      o_err_count,
   output logic                 o_err_any
);

   // The history needs seven clean samples after the first PRBS bit returns,
   // which takes latency cycles to come back through the chain.
   localparam logic [LATW:0] c_warm_extra = (LATW+1)'(7);

   logic [6:0]      r_hist;
   logic [LATW:0]   r_warm;
   logic [ERRW-1:0] r_err_cnt;
   logic            r_err_any;
   logic [LATW:0]   w_warm_end;
   logic            w_cmp_en;
   logic            w_err;

   // Compare only after warm-up; any mismatch is one bit error
   always_comb begin
      w_warm_end = {1'b0, i_latency} + c_warm_extra;
      w_cmp_en   = i_run && (r_warm >= w_warm_end);
      w_err      = w_cmp_en && (i_din != prbs7_expect(r_hist));
   end

   // Received-bit history, newest at [0]; shifting outside RUN is harmless
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist <= '0;
      end else begin
         r_hist <= {r_hist[5:0], i_din};
      end
   end

   // Warm-up counter: restarts at every RUN entry, holds once comparison opens
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_warm <= '0;
      end else if (!i_run) begin
         r_warm <= '0;
      end else if (!w_cmp_en) begin
         r_warm <= r_warm + 1'b1;
      end
   end

   // Saturating error counter and sticky flag, cleared at test start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
         r_err_any <= 1'b0;
      end else if (i_clr) begin
         r_err_cnt <= '0;
         r_err_any <= 1'b0;
      end else if (w_err) begin
         if (r_err_cnt != {ERRW{1'b1}}) begin
            r_err_cnt <= r_err_cnt + 1'b1;
         end
         r_err_any <= 1'b1;
      end
   end

   assign o_err_count = r_err_cnt;
   assign o_err_any   = r_err_any;

endmodule
`default_nettype wire

// File: rtl/delaychain_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : delaychain_tester                                            |
// | Description : Drives the delay-chain lanes: flush, marker pulse, latency   |
// |               measurement, then PRBS7 streaming with per-lane checking.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module delaychain_tester
   import delaychain_pkg::*;
#(
   parameter int LANES   = 8,
   parameter int MAX_LAT = c_max_lat_dflt,
   parameter int LATW    = 8,
   parameter int ERRW    = 16
) (
   input  wire logic    clk,
   input  wire logic    rst,
   delaychain_if.slave  bus
);

   localparam int                c_sel_w     = $clog2(LANES);
   localparam logic [LATW-1:0]   c_max_lat   = LATW'(MAX_LAT);
   localparam logic [LATW-1:0]   c_cnt_one   = LATW'(1);
   localparam logic [c_sel_w:0]  c_lanes_sel = (c_sel_w+1)'(LANES);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LATW-1:0]  r_cnt;
   logic [6:0]       r_lfsr;
   logic [LANES-1:0] r_chain_din;
   logic             r_busy;
   logic             r_lat_valid;
   logic             r_timeout;
   logic [LATW-1:0]  r_latency;
   logic [LANES-1:0] r_lat_skew;

   logic             w_clr;
   logic             w_capture;
   logic             w_timeout_hit;
   logic             w_run;
   logic [ERRW-1:0]  w_lane_cnt [LANES];
   logic [LANES-1:0] w_err_any;
   logic [ERRW-1:0]  w_err_count;

   // Next-state decode; the shared counter times both FLUSH and MEASURE
   always_comb begin
      w_state_nxt   = r_state;
      w_clr         = 1'b0;
      w_capture     = 1'b0;
      w_timeout_hit = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_clr       = 1'b1;
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (r_cnt == c_max_lat) begin
               w_state_nxt = ST_PULSE;
            end
         end
         ST_PULSE: begin
            w_state_nxt = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (bus.chain_dout[0]) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RUN;
            end else if (r_cnt == c_max_lat) begin
               w_timeout_hit = 1'b1;
               w_state_nxt   = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Cycle counter: FLUSH cycle index, then latency count from the pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_clr || (r_state == ST_PULSE)) begin
         r_cnt <= c_cnt_one;
      end else if ((r_state == ST_FLUSH) || (r_state == ST_MEASURE)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Latency capture, skew flags and timeout; results hold until next start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_latency   <= '0;
         r_lat_valid <= 1'b0;
         r_timeout   <= 1'b0;
         r_lat_skew  <= '0;
      end else if (w_clr) begin
         r_latency   <= '0;
         r_lat_valid <= 1'b0;
         r_timeout   <= 1'b0;
         r_lat_skew  <= '0;
      end else if (r_state == ST_MEASURE) begin
         if (w_capture) begin
            r_latency   <= r_cnt;
            r_lat_valid <= 1'b1;
            // Lanes still low when lane 0 arrives are late
            r_lat_skew  <= r_lat_skew | ~bus.chain_dout;
         end else begin
            // Lanes arriving before lane 0 are early
            r_lat_skew  <= r_lat_skew | bus.chain_dout;
         end
         if (w_timeout_hit) begin
            r_timeout <= 1'b1;
         end
      end
   end

   // Registered chain drive and busy; LFSR sits at seed outside RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chain_din <= '0;
         r_busy      <= 1'b0;
         r_lfsr      <= c_prbs7_seed;
      end else begin
         r_busy <= (w_state_nxt != ST_IDLE);
         if (w_state_nxt == ST_PULSE) begin
            r_chain_din <= '1;
         end else if (w_state_nxt == ST_RUN) begin
            r_chain_din <= {LANES{r_lfsr[0]}};
         end else begin
            r_chain_din <= '0;
         end
         r_lfsr <= (w_state_nxt == ST_RUN) ? prbs7_next(r_lfsr) : c_prbs7_seed;
      end
   end

   assign w_run = (r_state == ST_RUN);

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         prbs7_check #(
            .LATW (LATW),
            .ERRW (ERRW)
         ) u_chk (
            .clk         (clk),
            .rst         (rst),
            .i_clr       (w_clr),
            .i_run       (w_run),
            .i_latency   (r_latency),
            .i_din       (bus.chain_dout[gi]),
            .o_err_count (w_lane_cnt[gi]),
            .o_err_any   (w_err_any[gi])
         );
      end
   endgenerate

   // Read-out mux over the registered lane counters
   always_comb begin
      w_err_count = '0;
      if ({1'b0, bus.err_sel} < c_lanes_sel) begin
         w_err_count = w_lane_cnt[bus.err_sel];
      end
   end

   assign bus.chain_din = r_chain_din;
   assign bus.busy      = r_busy;
   assign bus.lat_valid = r_lat_valid;
   assign bus.timeout   = r_timeout;
   assign bus.latency   = r_latency;
   assign bus.lat_skew  = r_lat_skew;
   assign bus.err_any   = w_err_any;
   assign bus.err_count = w_err_count;

endmodule
`default_nettype wire

// File: tb/tb_delaychain_tester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_delaychain_tester                                         |
// | Description : Bench for delaychain_tester with a flop-chain lane model,    |
// |               random bit faults and a reference error model.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_delaychain_tester;

   localparam int LANES   = 8;
   localparam int MAX_LAT = 255;
   localparam int LATW    = 8;
   localparam int ERRW    = 16;
   localparam int SRW     = 300;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   delaychain_if #(.LANES(LANES), .LATW(LATW), .ERRW(ERRW)) bus ();

   delaychain_tester #(
      .LANES   (LANES),
      .MAX_LAT (MAX_LAT),
      .LATW    (LATW),
      .ERRW    (ERRW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Chain model: lane i is len[i] flops; fault masks act on the outputs
   logic [SRW-1:0]   sr [LANES];
   int               len [LANES];
   logic [LANES-1:0] raw, flip_m, s1_m, s0_m;

   always @(posedge clk) begin
      for (int i = 0; i < LANES; i++) sr[i] <= {sr[i][SRW-2:0], bus.chain_din[i]};
   end

   always_comb begin
      raw = '0;
      for (int i = 0; i < LANES; i++) raw[i] = sr[i][len[i]-1];
   end

   assign bus.chain_dout = ((raw ^ flip_m) | s1_m) & ~s0_m;

   int               checks = 0;
   int               errors = 0;
   logic             prbs_ref [64];
   int               flip_cyc[$];
   int               flip_lane[$];
   int               stuck1_lane;
   logic [LANES-1:0] samp[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One full test: start, optional ignored restart, RUN for run_len cycles,
   // stop, then compare every result against the reference model.
   task automatic run_test(input string name, input int run_len, input int restart_at);
      int               j, l0, cnt;
      logic [LANES-1:0] skew_exp, any_exp;
      int               cnt_exp [LANES];
      l0 = len[0];
      skew_exp = '0;
      for (int i = 0; i < LANES; i++) if (len[i] != l0) skew_exp[i] = 1'b1;
      samp.delete();

      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      check({name, ":busy_on"}, 32'(bus.busy), 1);
      check({name, ":clr_any"}, 32'(bus.err_any), 0);

      j = 1;
      while (!bus.lat_valid && j < 1000) begin
         @(negedge clk);
         j++;
         bus.start = (j == restart_at);
      end
      bus.start = 1'b0;
      check({name, ":capture_cycle"}, j, MAX_LAT + 2 + l0);
      if (!bus.lat_valid) return;

      for (int k = 1; k <= run_len; k++) begin
         flip_m = '0;
         foreach (flip_cyc[f]) if (flip_cyc[f] == k) flip_m[flip_lane[f]] = 1'b1;
         s1_m = '0;
         if (stuck1_lane >= 0) s1_m[stuck1_lane] = 1'b1;
         bus.stop = (k == run_len);
         #1;
         samp.push_back(bus.chain_dout);
         if (k <= 64) check({name, ":prbs_out"}, 32'(bus.chain_din), 32'({LANES{prbs_ref[k-1]}}));
         @(negedge clk);
      end
      bus.stop = 1'b0;
      flip_m = '0;
      s1_m = '0;

      // Reference: after latency+7 RUN cycles, bit k must equal bit(k-7)^bit(k-6)
      any_exp = '0;
      for (int i = 0; i < LANES; i++) begin
         cnt = 0;
         for (int k = l0 + 8; k <= run_len; k++)
            if (samp[k-1][i] != (samp[k-8][i] ^ samp[k-7][i])) cnt++;
         cnt_exp[i] = (cnt > 65535) ? 65535 : cnt;
         if (cnt > 0) any_exp[i] = 1'b1;
      end

      check({name, ":busy_off"}, 32'(bus.busy), 0);
      check({name, ":latency"}, 32'(bus.latency), l0);
      check({name, ":lat_valid"}, 32'(bus.lat_valid), 1);
      check({name, ":timeout"}, 32'(bus.timeout), 0);
      check({name, ":lat_skew"}, 32'(bus.lat_skew), 32'(skew_exp));
      check({name, ":err_any"}, 32'(bus.err_any), 32'(any_exp));
      for (int i = 0; i < LANES; i++) begin
         bus.err_sel = 3'(i);
         #1;
         check($sformatf("%s:err_count%0d", name, i), 32'(bus.err_count), cnt_exp[i]);
      end
   endtask

   task automatic set_len(input int n);
      for (int i = 0; i < LANES; i++) len[i] = n;
   endtask

   initial begin
      int j, n;
      for (int i = 0; i < 64; i++) prbs_ref[i] = (i < 7) ? 1'b1 : (prbs_ref[i-7] ^ prbs_ref[i-6]);
      rst = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0; bus.err_sel = '0;
      flip_m = '0; s1_m = '0; s0_m = '0;
      stuck1_lane = -1;
      set_len(80);

      repeat (3) @(negedge clk);
      #1;
      check("reset:chain_din", 32'(bus.chain_din), 0);
      check("reset:busy", 32'(bus.busy), 0);
      check("reset:lat_valid", 32'(bus.lat_valid), 0);
      check("reset:timeout", 32'(bus.timeout), 0);
      check("reset:latency", 32'(bus.latency), 0);
      check("reset:lat_skew", 32'(bus.lat_skew), 0);
      check("reset:err_any", 32'(bus.err_any), 0);
      check("reset:err_count", 32'(bus.err_count), 0);
      @(negedge clk); rst = 1'b0;

      // Clean 80-flop chains
      run_test("base", 2000, 0);

      // Single flipped bit on lane 3
      flip_cyc.push_back(500); flip_lane.push_back(3);
      run_test("flip3", 1000, 0);
      bus.err_sel = 3'd3; #1;
      check("flip3:three_errors", 32'(bus.err_count), 3);
      check("flip3:any_mask", 32'(bus.err_any), 32'h08);
      flip_cyc.delete(); flip_lane.delete();

      // Lane 5 one flop longer
      len[5] = 81;
      run_test("skew5", 1000, 0);
      check("skew5:mask", 32'(bus.lat_skew), 32'h20);
      bus.err_sel = 3'd5; #1;
      check("skew5:no_errors", 32'(bus.err_count), 0);
      set_len(80);

      // Outputs stuck low: timeout after MAX_LAT measure cycles
      s0_m = '1;
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      j = 1;
      while (bus.busy && j < 2000) begin @(negedge clk); j++; end
      check("tmo:busy_cycles", j, 2 * MAX_LAT + 2);
      check("tmo:timeout", 32'(bus.timeout), 1);
      check("tmo:lat_valid", 32'(bus.lat_valid), 0);
      check("tmo:latency", 32'(bus.latency), 0);
      s0_m = '0;

      // Random lane lengths and random single-bit faults
      len[0] = int'($urandom_range(20, 120));
      for (int i = 1; i < LANES; i++)
         len[i] = ($urandom_range(0, 1) == 0) ? len[0] : int'($urandom_range(1, 200));
      for (int f = 0; f < 4; f++) begin
         flip_cyc.push_back(int'($urandom_range(len[0] + 10, 990)));
         flip_lane.push_back(int'($urandom_range(0, LANES - 1)));
      end
      run_test("random", 1000, 0);
      flip_cyc.delete(); flip_lane.delete();
      set_len(80);

      // Lane 0 stuck high through RUN: counter saturation
      stuck1_lane = 0;
      run_test("sat0", 80 + 7 + 65600, 0);
      bus.err_sel = 3'd0; #1;
      check("sat0:saturated", 32'(bus.err_count), 32'hFFFF);
      stuck1_lane = -1;

      // Reset in RUN, then a new test with an ignored start during FLUSH
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      n = 1;
      while (!bus.lat_valid && n < 1000) begin @(negedge clk); n++; end
      check("rst:pre_capture", 32'(bus.lat_valid), 1);
      s1_m = 8'h04;
      repeat (150) @(negedge clk);
      bus.err_sel = 3'd2; #1;
      check("rst:pre_errs", 32'(bus.err_count != 0), 1);
      #1 rst = 1'b1;
      #1;
      check("rst:chain_din", 32'(bus.chain_din), 0);
      check("rst:busy", 32'(bus.busy), 0);
      check("rst:lat_valid", 32'(bus.lat_valid), 0);
      check("rst:latency", 32'(bus.latency), 0);
      check("rst:lat_skew", 32'(bus.lat_skew), 0);
      check("rst:err_any", 32'(bus.err_any), 0);
      check("rst:err_count", 32'(bus.err_count), 0);
      @(negedge clk); rst = 1'b0; s1_m = '0;
      run_test("restart", 500, 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
